// File: rtl/regfile_mp.sv
// Multi-read-port register file with byte-strobed writes, per-entry valid bits and an invalidate-all sweep.
// Define REGFILE_MP_BYPASS_EN to forward a same-cycle accepted write onto matching read ports.

module regfile_mp_rport #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int DATA_W = 32,
  parameter int STRB_W = DATA_W/8
) (
  input  logic [DEPTH-1:0][DATA_W-1:0] mem_i,
  input  logic [DEPTH-1:0]             vld_i,
  input  logic [ADDR_W-1:0]            raddr_i,
`ifdef REGFILE_MP_BYPASS_EN
  input  logic                         wr_acc_i,
  input  logic [ADDR_W-1:0]            waddr_i,
  input  logic [DATA_W-1:0]            wdata_i,
  input  logic [STRB_W-1:0]            wstrb_i,
`endif
  output logic [DATA_W-1:0]            rdata_o,
  output logic                         rvalid_o
);
  // Compare-select rather than direct index so out-of-range addresses read as 0 / invalid.
  always_comb begin
    rdata_o  = '0;
    rvalid_o = 1'b0;
    for (int e = 0; e < DEPTH; e++) begin
      if (raddr_i == ADDR_W'(e)) begin
        rdata_o  = mem_i[e];
        rvalid_o = vld_i[e];
      end
    end
`ifdef REGFILE_MP_BYPASS_EN
    if (wr_acc_i && (raddr_i == waddr_i)) begin
      for (int b = 0; b < STRB_W; b++)
        if (wstrb_i[b]) rdata_o[8*b +: 8] = wdata_i[8*b +: 8];
      rvalid_o = 1'b1;
    end
`endif
  end
endmodule

module regfile_mp #(
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int DATA_W   = 32,
  parameter int STRB_W   = DATA_W/8,
  parameter int RD_PORTS = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [RD_PORTS*ADDR_W-1:0]   raddr,
  output logic [RD_PORTS*DATA_W-1:0]   rdata,
  output logic [RD_PORTS-1:0]          rvalid,
  input  logic                         wen,
  input  logic [ADDR_W-1:0]            waddr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [STRB_W-1:0]            wstrb,
  input  logic                         inv_req,
  output logic                         inv_busy,
  output logic                         inv_done
);
  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_e;

  state_e                     state_q, state_d;
  logic [ADDR_W-1:0]          ptr_q, ptr_d;
  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [DEPTH-1:0]           vld_q;
  logic                       wr_acc;

  assign wr_acc   = wen && (state_q != SWEEP) && (32'(waddr) < DEPTH);
  assign inv_busy = (state_q == SWEEP);
  assign inv_done = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE:  if (inv_req) begin state_d = SWEEP; ptr_d = '0; end
      SWEEP: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == ADDR_W'(DEPTH-1)) begin state_d = DONE; ptr_d = '0; end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Sweep clear takes priority; writes cannot coincide with it since SWEEP drops them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '0;
      vld_q <= '0;
    end else begin
      for (int e = 0; e < DEPTH; e++) begin
        if ((state_q == SWEEP) && (ptr_q == ADDR_W'(e))) begin
          mem_q[e] <= '0;
          vld_q[e] <= 1'b0;
        end else if (wr_acc && (waddr == ADDR_W'(e))) begin
          vld_q[e] <= 1'b1;
          for (int b = 0; b < STRB_W; b++)
            if (wstrb[b]) mem_q[e][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  for (genvar p = 0; p < RD_PORTS; p++) begin : g_rd
    regfile_mp_rport #(
      .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)
    ) u_rport (
      .mem_i    (mem_q),
      .vld_i    (vld_q),
      .raddr_i  (raddr[p*ADDR_W +: ADDR_W]),
`ifdef REGFILE_MP_BYPASS_EN
      .wr_acc_i (wr_acc),
      .waddr_i  (waddr),
      .wdata_i  (wdata),
      .wstrb_i  (wstrb),
`endif
      .rdata_o  (rdata[p*DATA_W +: DATA_W]),
      .rvalid_o (rvalid[p])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a DEPTH=32 instance for the main function and a DEPTH=20 instance for range/abort cases.

module tb_regfile_mp;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int c;

  // DEPTH=32 instance
  logic        a_rst, a_wen, a_req, a_busy, a_done;
  logic [9:0]  a_raddr;
  logic [63:0] a_rdata;
  logic [1:0]  a_rvalid;
  logic [4:0]  a_waddr;
  logic [31:0] a_wdata;
  logic [3:0]  a_wstrb;

  regfile_mp #(.DEPTH(32)) u_a (
    .clk(clk), .reset(a_rst), .raddr(a_raddr), .rdata(a_rdata), .rvalid(a_rvalid),
    .wen(a_wen), .waddr(a_waddr), .wdata(a_wdata), .wstrb(a_wstrb),
    .inv_req(a_req), .inv_busy(a_busy), .inv_done(a_done)
  );

  // DEPTH=20 instance
  logic        b_rst, b_wen, b_req, b_busy, b_done;
  logic [9:0]  b_raddr;
  logic [63:0] b_rdata;
  logic [1:0]  b_rvalid;
  logic [4:0]  b_waddr;
  logic [31:0] b_wdata;
  logic [3:0]  b_wstrb;

  regfile_mp #(.DEPTH(20)) u_b (
    .clk(clk), .reset(b_rst), .raddr(b_raddr), .rdata(b_rdata), .rvalid(b_rvalid),
    .wen(b_wen), .waddr(b_waddr), .wdata(b_wdata), .wstrb(b_wstrb),
    .inv_req(b_req), .inv_busy(b_busy), .inv_done(b_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr_a(input logic [4:0] ad, input logic [31:0] d, input logic [3:0] s);
    a_wen = 1'b1; a_waddr = ad; a_wdata = d; a_wstrb = s;
    tick();
    a_wen = 1'b0;
  endtask

  task automatic rd_a(input logic [4:0] p0, input logic [4:0] p1);
    a_raddr = {p1, p0};
    #1;
  endtask

  initial begin
    a_rst = 1'b0; a_wen = 1'b0; a_req = 1'b0; a_raddr = '0; a_waddr = '0; a_wdata = '0; a_wstrb = '0;
    b_rst = 1'b0; b_wen = 1'b0; b_req = 1'b0; b_raddr = '0; b_waddr = '0; b_wdata = '0; b_wstrb = '0;
    tick(); tick();
    rd_a(5'd0, 5'd31);
    chk("rst_rdata0", a_rdata[31:0], 32'h0);
    chk("rst_rvalid", {30'd0, a_rvalid}, 32'h0);
    chk("rst_busy", {31'd0, a_busy}, 32'h0);
    chk("rst_done", {31'd0, a_done}, 32'h0);
    a_rst = 1'b1; b_rst = 1'b1;
    tick();

    // full write, then two-port read
    wr_a(5'd5, 32'hA5A5A5A5, 4'hF);
    rd_a(5'd5, 5'd6);
    chk("wr5_data", a_rdata[31:0], 32'hA5A5A5A5);
    chk("wr5_valid", {31'd0, a_rvalid[0]}, 32'h1);
    chk("rd6_data", a_rdata[63:32], 32'h0);
    chk("rd6_valid", {31'd0, a_rvalid[1]}, 32'h0);

    // byte strobes
    wr_a(5'd3, 32'h11223344, 4'hF);
    wr_a(5'd3, 32'hFFFFFFFF, 4'h5);
    rd_a(5'd3, 5'd5);
    chk("strb_data", a_rdata[31:0], 32'h11FF33FF);
    chk("strb_valid", {31'd0, a_rvalid[0]}, 32'h1);

    // same-cycle read of a write in flight
    a_raddr = {5'd9, 5'd0};
    a_wen = 1'b1; a_waddr = 5'd9; a_wdata = 32'hDEADBEEF; a_wstrb = 4'hF;
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    chk("byp_data", a_rdata[63:32], 32'hDEADBEEF);
    chk("byp_valid", {31'd0, a_rvalid[1]}, 32'h1);
`else
    chk("nobyp_data", a_rdata[63:32], 32'h0);
    chk("nobyp_valid", {31'd0, a_rvalid[1]}, 32'h0);
`endif
    tick();
    a_wen = 1'b0;
    #1;
    chk("wr9_data", a_rdata[63:32], 32'hDEADBEEF);
    chk("wr9_valid", {31'd0, a_rvalid[1]}, 32'h1);

    // zero strobe still sets valid
    wr_a(5'd10, 32'h12345678, 4'h0);
    rd_a(5'd10, 5'd10);
    chk("strb0_data", a_rdata[31:0], 32'h0);
    chk("strb0_valid", {31'd0, a_rvalid[0]}, 32'h1);

    // fill and sweep
    for (int e = 0; e < 32; e++) wr_a(5'(e), 32'h100 + e, 4'hF);
    rd_a(5'd5, 5'd31);
    chk("fill_5", a_rdata[31:0], 32'h105);
    chk("fill_31", a_rdata[63:32], 32'h11F);

    a_req = 1'b1;
    tick();
    a_req = 1'b0;
    c = 0;
    while (a_busy && c < 40) begin
      c++;
      chk("sw1_nodone", {31'd0, a_done}, 32'h0);
      if (c == 3) begin
        rd_a(5'd1, 5'd31);
        chk("sw1_clr1_data", a_rdata[31:0], 32'h0);
        chk("sw1_clr1_valid", {31'd0, a_rvalid[0]}, 32'h0);
        chk("sw1_old31_data", a_rdata[63:32], 32'h11F);
        chk("sw1_old31_valid", {31'd0, a_rvalid[1]}, 32'h1);
      end
      if (c == 5) begin
        a_wen = 1'b1; a_waddr = 5'd0; a_wdata = 32'hBAD0BAD0; a_wstrb = 4'hF;
      end
      tick();
      a_wen = 1'b0;
    end
    chk("sw1_len", c, 32);
    chk("sw1_done", {31'd0, a_done}, 32'h1);
    chk("sw1_busy_off", {31'd0, a_busy}, 32'h0);
    a_req = 1'b1;
    tick();
    a_req = 1'b0;
    chk("sw1_done_pulse", {31'd0, a_done}, 32'h0);
    tick();
    chk("done_req_ignored", {31'd0, a_busy}, 32'h0);
    for (int e = 0; e < 32; e++) begin
      rd_a(5'(e), 5'(31 - e));
      chk("sw1_clear_data", a_rdata[31:0], 32'h0);
      chk("sw1_clear_valid", {31'd0, a_rvalid[0]}, 32'h0);
    end

    // request together with a write to entry 7
    a_req = 1'b1; a_wen = 1'b1; a_waddr = 5'd7; a_wdata = 32'h1; a_wstrb = 4'hF;
    tick();
    a_req = 1'b0; a_wen = 1'b0;
    rd_a(5'd7, 5'd0);
    c = 0;
    while (a_busy && c < 40) begin
      c++;
      if (c == 1 || c == 8) begin
        chk("sw2_keep_data", a_rdata[31:0], 32'h1);
        chk("sw2_keep_valid", {31'd0, a_rvalid[0]}, 32'h1);
      end
      if (c == 9) begin
        chk("sw2_clr_data", a_rdata[31:0], 32'h0);
        chk("sw2_clr_valid", {31'd0, a_rvalid[0]}, 32'h0);
      end
      tick();
    end
    chk("sw2_len", c, 32);
    chk("sw2_done", {31'd0, a_done}, 32'h1);
    tick();

    // DEPTH=20: out-of-range write and read
    b_wen = 1'b1; b_waddr = 5'd19; b_wdata = 32'h77; b_wstrb = 4'hF;
    tick();
    b_waddr = 5'd25; b_wdata = 32'hFFFF;
    tick();
    b_wen = 1'b0;
    b_raddr = {5'd25, 5'd19};
    #1;
    chk("b_19_data", b_rdata[31:0], 32'h77);
    chk("b_25_data", b_rdata[63:32], 32'h0);
    chk("b_25_valid", {31'd0, b_rvalid[1]}, 32'h0);
    b_raddr = {5'd9, 5'd9};
    #1;
    chk("b_9_valid", {31'd0, b_rvalid[0]}, 32'h0);

    b_req = 1'b1;
    tick();
    b_req = 1'b0;
    c = 0;
    while (b_busy && c < 40) begin
      c++;
      tick();
    end
    chk("b_sw_len", c, 20);
    chk("b_sw_done", {31'd0, b_done}, 32'h1);
    tick();

    // reset aborts an in-progress sweep
    b_wen = 1'b1; b_waddr = 5'd19; b_wdata = 32'h55; b_wstrb = 4'hF;
    tick();
    b_waddr = 5'd4; b_wdata = 32'h44;
    tick();
    b_wen = 1'b0;
    b_req = 1'b1;
    tick();
    b_req = 1'b0;
    tick(); tick(); tick();
    b_raddr = {5'd4, 5'd19};
    #1;
    chk("b_mid_19", b_rdata[31:0], 32'h55);
    chk("b_mid_busy", {31'd0, b_busy}, 32'h1);
    b_rst = 1'b0;
    #1;
    chk("b_abort_busy", {31'd0, b_busy}, 32'h0);
    chk("b_abort_done", {31'd0, b_done}, 32'h0);
    chk("b_abort_19", b_rdata[31:0], 32'h0);
    chk("b_abort_4", b_rdata[63:32], 32'h0);
    chk("b_abort_valid", {30'd0, b_rvalid}, 32'h0);
    tick();
    b_rst = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file used for cache tag, valid and data side-arrays. It is the successor to the single-port, flop-based `regfile`. It adds:
- `RD_PORTS` independent combinational read ports;
- byte-strobed writes;
- a per-entry valid bit;
- a sequential invalidate-all sweep engine that clears every entry one per cycle, with a busy/done handshake.

## Interface
- `DEPTH`, 32, number of entries (any value ≥ 2; power of two not required)
- `ADDR_W`, `$clog2(DEPTH)`, address width
- `DATA_W`, 32, entry width; must be a multiple of 8
- `STRB_W`, `DATA_W/8`, byte-strobe width
- `RD_PORTS`, 2, number of read ports (≥ 1)

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `raddr`  in  `RD_PORTS*ADDR_W`  packed read addresses; port p uses bits `[p*ADDR_W +: ADDR_W]`
- `rdata`  out  `RD_PORTS*DATA_W`  packed read data, combinational from the current entry contents
- `rvalid`  out  `RD_PORTS`  valid bit of the addressed entry, one bit per port
- `wen`  in  1  write enable
- `waddr`  in  `ADDR_W`  write address
- `wdata`  in  `DATA_W`  write data
- `wstrb`  in  `STRB_W`  byte enables; bit b writes `wdata[8b+7:8b]`
- `inv_req`  in  1  single-cycle request to start the invalidate-all sweep
- `inv_busy`  out  1  high while the sweep is running
- `inv_done`  out  1  one-cycle pulse when the sweep completes

## Operation
- States: IDLE, SWEEP, DONE. Sweep pointer `ptr` is `ADDR_W` bits wide.
- Reset (`reset`=0), applied asynchronously:
  - all data cleared to 0 and all valid bits to 0;
  - state forced to IDLE and `ptr` to 0;
  - `inv_busy`=0, `inv_done`=0.
- Write, accepted in IDLE and DONE:
  - enabled bytes of `waddr` take the `wdata` bytes; other bytes hold their value;
  - the valid bit is set whenever `wen`=1, including when `wstrb`=0.
- `waddr` ≥ DEPTH: the write is dropped.
- Read, every port independent:
  - `rdata` returns the stored entry and `rvalid` its valid bit;
  - `raddr` ≥ DEPTH returns `rdata`=0, `rvalid`=0.
- IDLE, `inv_req`=1: move to SWEEP with `ptr`=0. A same-cycle write is still performed; the sweep later clears that entry.
- SWEEP, each edge:
  - clear data and valid of entry `ptr`, then increment `ptr`;
  - on the edge that clears entry DEPTH-1, move to DONE.
- SWEEP, other inputs:
  - `wen` is ignored (dropped), and the requester must hold off while `inv_busy`=1;
  - `inv_req` is ignored.
- DONE: `inv_done`=1 for exactly one cycle, then IDLE. `inv_req` is ignored in DONE.
- Reads stay legal during SWEEP:
  - already-cleared entries read 0 / invalid;
  - entries not yet reached read their old contents.
- Reset asserted mid-sweep aborts the sweep immediately; all entries are cleared by the reset itself.

## Timing
- Write latency: data and valid are visible on reads in the cycle after the write edge.
- Read path: combinational from the registers, zero cycles.
- Invalidate: request sampled at edge T. `inv_busy`=1 from T+1 for exactly DEPTH cycles. `inv_done`=1 in cycle T+DEPTH+1. New writes and requests are accepted from that same DONE cycle (writes) or from T+DEPTH+2 (requests).
- `inv_busy` and `inv_done` are registered state decodes and are never high together.

## Configuration
- Macro `REGFILE_MP_BYPASS_EN`.
- Defined: a read port whose `raddr` equals `waddr` while a write is accepted that cycle returns forwarded data in the same cycle:
  - enabled bytes come from `wdata`, the rest from the stored entry;
  - `rvalid`=1.
- Forwarding never occurs during SWEEP, because writes are dropped there.
- Undefined: reads always return the stored contents; a same-cycle write is visible only from the next cycle.

## Test plan
- Reset, then write addr 5 = 0xA5A5A5A5 with `wstrb`=0xF -> next cycle port0 raddr 5 reads 0xA5A5A5A5, rvalid=1; port1 raddr 6 reads 0, rvalid=0.
- Write addr 3 = 0x11223344 (strb 0xF), then 0xFFFFFFFF with strb 0x5 -> addr 3 reads 0x11FF33FF, rvalid=1.
- Fill all 32 entries, pulse `inv_req` -> `inv_busy` high for exactly 32 cycles, then `inv_done` for 1 cycle. A `wen` to addr 0 mid-sweep is dropped. All entries read 0 with rvalid=0 afterwards.
- Pulse `inv_req` together with a write to addr 7 = 0x1 -> addr 7 reads 0x1 during the early sweep, then 0 / invalid after its clear cycle.
- With `REGFILE_MP_BYPASS_EN`: write addr 9 = 0xDEADBEEF while port1 reads addr 9 -> same-cycle rdata 0xDEADBEEF, rvalid=1. Without the macro: old value, rvalid=0.
- DEPTH=20: write addr 25 -> no entry changes; raddr 25 reads 0, rvalid=0. Assert reset mid-sweep -> `inv_busy`=0 immediately and all entries cleared.
